// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_LOOP = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    PREP = ST_PREP,
    LOOP = ST_LOOP,
    FIX  = ST_FIX
  } state_t;

endpackage

// File: rtl/div_restoring_n_if.sv
// Request/result bundle of the restoring divider, plus the FSM state for observation.
interface div_restoring_n_if #(parameter int WIDTH = 32) ();
  import div_pkg::*;

  // Handshake: start is sampled only on an edge where busy is 0. Operands latch
  // on that edge. busy stays high until results are loaded, then done pulses for
  // one cycle; q_out/r_out/div_zero hold until the next operation completes.
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             signed_op;
  logic             start;
  logic [WIDTH-1:0] q_out;
  logic [WIDTH-1:0] r_out;
  logic             busy;
  logic             done;
  logic             div_zero;
  state_t           dbg_state;

  modport master (
    output a_in, b_in, signed_op, start,
    input  q_out, r_out, busy, done, div_zero, dbg_state
  );

  modport slave (
    input  a_in, b_in, signed_op, start,
    output q_out, r_out, busy, done, div_zero, dbg_state
  );

endinterface

// File: rtl/div_rest_step.sv
// One restoring division step: trial subtract of the divisor from {remainder, next bit}.
module div_rest_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] trial;
  logic           borrow;
  logic           step_unused;

  assign partial = {rem_i, bit_i};
  assign {borrow, trial} = {1'b0, partial} - {2'b00, dvs_i};
  assign q_bit_o = ~borrow;

  // Remainder stays below the divisor, so the top bit is always zero after selection.
  assign rem_o = borrow ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_unused = partial[WIDTH] ^ trial[WIDTH];

endmodule

// File: rtl/div_restoring_n.sv
// Multi-cycle restoring divider (signed/unsigned) with IDLE/PREP/LOOP/FIX control.
module div_restoring_n
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rstLow,
  div_restoring_n_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic             qneg_q, rneg_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] q_res_q, r_res_q;
  logic             dz_res_q, done_q;

  logic ld_op, ld_prep, ld_step, ld_fix, busy;

  logic [WIDTH-1:0] a_mag, b_mag, rem_nx, q_fix, r_fix;
  logic             q_bit, dz;

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREP;
      PREP:    state_d = (b_q == '0) ? FIX : LOOP;
      LOOP:    if (cnt_q == LAST_ITER) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_op   = (state_q == IDLE) && bus.start;
    ld_prep = (state_q == PREP);
    ld_step = (state_q == LOOP);
    ld_fix  = (state_q == FIX);
    busy    = (state_q != IDLE);
  end

  // Magnitudes: the most-negative value maps to 2^(WIDTH-1), which is correct unsigned.
  assign a_mag = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;

  div_rest_step #(.WIDTH(WIDTH)) u_step (
    .rem_i   (rem_q),
    .bit_i   (dvd_q[WIDTH-1]),
    .dvs_i   (dvs_q),
    .rem_o   (rem_nx),
    .q_bit_o (q_bit)
  );

  // Zero divisor returns all-ones quotient and the untouched original dividend.
  assign dz    = (b_q == '0);
  assign q_fix = dz ? '1  : (qneg_q ? -dvd_q : dvd_q);
  assign r_fix = dz ? a_q : (rneg_q ? -rem_q : rem_q);

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      q_res_q  <= '0;
      r_res_q  <= '0;
      dz_res_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= ld_fix;
      if (ld_op) begin
        a_q   <= bus.a_in;
        b_q   <= bus.b_in;
        sgn_q <= bus.signed_op;
      end
      if (ld_prep) begin
        dvd_q  <= a_mag;
        dvs_q  <= b_mag;
        rem_q  <= '0;
        cnt_q  <= '0;
        qneg_q <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_q <= sgn_q & a_q[WIDTH-1];
      end
      if (ld_step) begin
        rem_q <= rem_nx;
        dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
        cnt_q <= cnt_q + CW'(1);
      end
      if (ld_fix) begin
        q_res_q  <= q_fix;
        r_res_q  <= r_fix;
        dz_res_q <= dz;
      end
    end
  end

  assign bus.q_out     = q_res_q;
  assign bus.r_out     = r_res_q;
  assign bus.div_zero  = dz_res_q;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_div_restoring_n.sv
// Bench for div_restoring_n: directed vector table, hand-written corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_div_restoring_n;
  import div_pkg::*;

  logic clk;
  logic rstLow;
  int   total = 0;
  int   bad   = 0;

  div_restoring_n_if #(.WIDTH(32)) bus32 ();
  div_restoring_n_if #(.WIDTH(8))  bus8 ();

  div_restoring_n #(.WIDTH(32)) dut32 (.clk(clk), .rstLow(rstLow), .bus(bus32));
  div_restoring_n #(.WIDTH(8))  dut8  (.clk(clk), .rstLow(rstLow), .bus(bus8));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];   // {q[31:0], r[31:0], div_zero}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division on sign- or zero-extended operands.
  function automatic logic [64:0] ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, qq, rr;
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if ((b & mask) == 32'd0) return {mask, a & mask, 1'b1};
    sa = longint'(a & mask);
    sb = longint'(b & mask);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    qq = sa / sb;
    rr = sa % sb;
    return {32'(qq) & mask, 32'(rr) & mask, 1'b0};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz,
                         output int bc, output int pulses);
    bit got;
    bc = 0; pulses = 0; got = 0; q = '0; r = '0; dz = 1'b0;
    bus32.a_in = a; bus32.b_in = b; bus32.signed_op = s; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    bus32.a_in = $urandom; bus32.b_in = $urandom; bus32.signed_op = 1'($urandom_range(0, 1));
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus32.busy) bc++;
      if (bus32.done) begin
        got = 1; pulses = 1;
        q = bus32.q_out; r = bus32.r_out; dz = bus32.div_zero;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout32: no done after 80 cycles");
    end
    @(negedge clk);
    if (bus32.done) pulses++;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [7:0] q, output logic [7:0] r, output logic dz,
                        output int bc);
    bit got;
    bc = 0; got = 0; q = '0; r = '0; dz = 1'b0;
    bus8.a_in = a; bus8.b_in = b; bus8.signed_op = s; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus8.busy) bc++;
      if (bus8.done) begin
        got = 1; q = bus8.q_out; r = bus8.r_out; dz = bus8.div_zero;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout8: no done after 40 cycles");
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] q, r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] q, r;
    logic [7:0]  q8, r8;
    logic        dz;
    logic [64:0] e;
    int          bc, pulses;
    bit          got;

    vecs[0]  = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0};
    vecs[1]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
    vecs[2]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0};
    vecs[3]  = '{32'h1234,      32'd0,         1'b0, 32'hFFFFFFFF,  32'h1234,      1'b1};
    vecs[4]  = '{32'h1234,      32'd0,         1'b1, 32'hFFFFFFFF,  32'h1234,      1'b1};
    vecs[5]  = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0};
    vecs[6]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 32'd3,         32'hFFFFFFFF,  1'b0};
    vecs[7]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 32'd0,         32'h80000000,  1'b0};
    vecs[8]  = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0};
    vecs[9]  = '{32'd5,         32'd10,        1'b0, 32'd0,         32'd5,         1'b0};
    vecs[10] = '{32'h80000000,  32'd0,         1'b1, 32'hFFFFFFFF,  32'h80000000,  1'b1};
    vecs[11] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'd1,         32'd0,         1'b0};

    // ---------------- reset ----------------
    bus32.a_in = '0; bus32.b_in = '0; bus32.signed_op = 1'b0; bus32.start = 1'b0;
    bus8.a_in  = '0; bus8.b_in  = '0; bus8.signed_op  = 1'b0; bus8.start  = 1'b0;
    rstLow = 1'b0;
    #1;
    check("rst_busy",  64'(bus32.busy), 64'd0);
    check("rst_done",  64'(bus32.done), 64'd0);
    check("rst_q",     64'(bus32.q_out), 64'd0);
    check("rst_r",     64'(bus32.r_out), 64'd0);
    check("rst_dz",    64'(bus32.div_zero), 64'd0);
    check("rst_state", 64'(bus32.dbg_state), 64'(IDLE));
    @(negedge clk);
    rstLow = 1'b1;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].q, vecs[i].r, vecs[i].dz});
      do_op32(vecs[i].a, vecs[i].b, vecs[i].s, q, r, dz, bc, pulses);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_q", i),  64'(q),  64'(e[64:33]));
      check($sformatf("vec%0d_r", i),  64'(r),  64'(e[32:1]));
      check($sformatf("vec%0d_dz", i), 64'(dz), 64'(e[0]));
      check($sformatf("vec%0d_busy_cycles", i), 64'(bc), (vecs[i].b == 32'd0) ? 64'd2 : 64'd34);
      check($sformatf("vec%0d_done_pulses", i), 64'(pulses), 64'd1);
    end

    // ---------------- random ----------------
    for (int n = 0; n < 120; n++) begin
      logic [31:0] a, b;
      logic        s;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; s = 1'b1; end
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 30);
      exp_q.push_back(ref_div(32, a, b, s));
      do_op32(a, b, s, q, r, dz, bc, pulses);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_q", n),  64'(q),  64'(e[64:33]));
      check($sformatf("rnd%0d_r", n),  64'(r),  64'(e[32:1]));
      check($sformatf("rnd%0d_dz", n), 64'(dz), 64'(e[0]));
    end

    // ---------------- back-to-back: start while done is high ----------------
    bus32.a_in = 32'd1000; bus32.b_in = 32'd3; bus32.signed_op = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus32.done) got = 1;
    end
    check("b2b_first_done", 64'(got), 64'd1);
    check("b2b_first_q", 64'(bus32.q_out), 64'd333);
    bus32.a_in = 32'd50; bus32.b_in = 32'd5; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    @(negedge clk);
    check("b2b_busy", 64'(bus32.busy), 64'd1);
    check("b2b_prior_q_held", 64'(bus32.q_out), 64'd333);
    check("b2b_prior_r_held", 64'(bus32.r_out), 64'd1);
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (bus32.done) got = 1;
    end
    check("b2b_second_done", 64'(got), 64'd1);
    check("b2b_second_q", 64'(bus32.q_out), 64'd10);
    check("b2b_second_r", 64'(bus32.r_out), 64'd0);

    // ---------------- WIDTH=8: 255/16 with start pulsed mid-LOOP ----------------
    @(negedge clk);
    bus8.a_in = 8'd255; bus8.b_in = 8'd16; bus8.signed_op = 1'b0; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    bc = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus8.busy) bc++;
      if (bus8.done) begin got = 1; q8 = bus8.q_out; r8 = bus8.r_out; dz = bus8.div_zero; end
      if (i == 4) begin bus8.a_in = 8'd3; bus8.b_in = 8'd1; bus8.start = 1'b1; end
      else bus8.start = 1'b0;
    end
    bus8.start = 1'b0;
    check("w8_done", 64'(got), 64'd1);
    check("w8_q", 64'(q8), 64'd15);
    check("w8_r", 64'(r8), 64'd15);
    check("w8_dz", 64'(dz), 64'd0);
    check("w8_busy_cycles", 64'(bc), 64'd10);
    bc = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus8.busy) bc++;
    end
    check("w8_no_queued_op", 64'(bc), 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] a, b;
      logic       s;
      a = 8'($urandom); b = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
      s = 1'($urandom_range(0, 1));
      if (n == 0) begin a = 8'h80; b = 8'hFF; s = 1'b1; end
      exp_q.push_back(ref_div(8, 32'(a), 32'(b), s));
      do_op8(a, b, s, q8, r8, dz, bc);
      e = exp_q.pop_front();
      check($sformatf("w8rnd%0d_q", n),  64'(q8), 64'(e[40:33]));
      check($sformatf("w8rnd%0d_r", n),  64'(r8), 64'(e[8:1]));
      check($sformatf("w8rnd%0d_dz", n), 64'(dz), 64'(e[0]));
      check($sformatf("w8rnd%0d_busy", n), 64'(bc), (b == 8'd0) ? 64'd2 : 64'd10);
      @(negedge clk);
    end

    // ---------------- asynchronous reset during LOOP ----------------
    do_op32(32'd100, 32'd7, 1'b0, q, r, dz, bc, pulses);
    check("prerst_q", 64'(q), 64'd14);
    bus32.a_in = 32'h0000FFFF; bus32.b_in = 32'd3; bus32.signed_op = 1'b0; bus32.start = 1'b1;
    @(posedge clk); #1;
    bus32.start = 1'b0;
    repeat (8) @(negedge clk);
    check("midloop_state", 64'(bus32.dbg_state), 64'(LOOP));
    #2 rstLow = 1'b0;
    #1;
    check("arst_busy",  64'(bus32.busy), 64'd0);
    check("arst_q",     64'(bus32.q_out), 64'd0);
    check("arst_r",     64'(bus32.r_out), 64'd0);
    check("arst_state", 64'(bus32.dbg_state), 64'(IDLE));
    @(negedge clk);
    rstLow = 1'b1;
    do_op32(32'd1000, 32'd9, 1'b0, q, r, dz, bc, pulses);
    check("postrst_q", 64'(q), 64'd111);
    check("postrst_r", 64'(r), 64'd1);
    check("postrst_busy_cycles", 64'(bc), 64'd34);
    check("postrst_done_pulses", 64'(pulses), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_restoring_n.md
DIV_RESTORING_N -- requirements
Module: div_restoring_n

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rstLow  input  1  reset, asynchronous, active-low.
REQ-004 Port: a_in  input  WIDTH  dividend.
REQ-005 Port: b_in  input  WIDTH  divisor.
REQ-006 Port: signed_op  input  1  1 = two's-complement DIV/REM, 0 = unsigned DIVU/REMU.
REQ-007 Port: start  input  1  operation request, sampled only while not busy.
REQ-008 Port: q_out  output  WIDTH  quotient.
REQ-009 Port: r_out  output  WIDTH  remainder.
REQ-010 Port: busy  output  1  operation in progress.
REQ-011 Port: done  output  1  one-cycle pulse, results valid.
REQ-012 Port: div_zero  output  1  last completed operation had b_in = 0; held with results.

Function
REQ-013 Operation uses states IDLE, PREP, LOOP, FIX.
REQ-014 Transitions: IDLE->PREP on start; PREP->FIX if latched divisor = 0, else PREP->LOOP; LOOP->FIX after exactly WIDTH iterations; FIX->IDLE unconditionally.
REQ-015 In IDLE with start=1: a_in, b_in and signed_op latch on that edge; later input changes do not affect the operation.
REQ-016 busy = 1 in PREP, LOOP and FIX; 0 in IDLE.
REQ-017 Latency: WIDTH+2 busy cycles for nonzero divisor; 2 busy cycles for zero divisor.
REQ-018 done pulses for one cycle in the first IDLE cycle after FIX.
REQ-019 start while busy = 1 is ignored; no queuing.
REQ-020 PREP: signed mode stores operand magnitudes and result signs (q sign = a XOR b; r sign = a); unsigned mode stores operands as-is.
REQ-021 LOOP: per iteration, one restoring step: WIDTH+1-bit trial subtract of divisor from {partial remainder, next dividend bit}; result nonnegative -> keep difference, shift in quotient bit 1; else restore, shift in 0.
REQ-022 Iteration counter is $clog2(WIDTH)+1 bits, cleared in PREP, incremented each LOOP cycle.
REQ-023 FIX: negate quotient and/or remainder per stored signs (signed mode only); load q_out, r_out, div_zero.
REQ-024 Divide by zero: q_out = all ones, r_out = original dividend (both modes); div_zero = 1.
REQ-025 Signed overflow (most-negative / -1): q_out = most-negative value, r_out = 0; div_zero = 0.
REQ-026 Remainder sign follows dividend; |r_out| < |divisor|; a = q*b + r exactly (mod 2^WIDTH).
REQ-027 q_out, r_out, div_zero hold their values from FIX until the next FIX.
REQ-028 If start is sampled in the same cycle that done is high, the new operation begins; prior results stay visible until its FIX.

Reset
REQ-029 rstLow = 0 forces, asynchronously: state IDLE, busy 0, done 0, q_out 0, r_out 0, div_zero 0, counter 0.
REQ-030 Reset mid-operation abandons it; no done pulse follows reset release.
REQ-031 After reset release, the first start is accepted on the first rising edge.

Structure
REQ-032 Shared package div_pkg holds the state enum (IDLE, PREP, LOOP, FIX) and the 2-bit state encoding constants.
REQ-033 One combinational sub-module, div_rest_step, parametrised by WIDTH, implements REQ-021; the top holds the FSM, registers, counter, sign handling.
REQ-034 No multi-cycle paths; one trial subtract per cycle.

Verification
REQ-035 WIDTH=32, unsigned, 100 / 7 -> q_out=14, r_out=2, busy high 34 cycles, single done pulse, div_zero=0.
REQ-036 WIDTH=32, signed, 0xFFFFFFF9 / 2 (-7/2) -> q_out=0xFFFFFFFD, r_out=0xFFFFFFFF.
REQ-037 WIDTH=32, signed, 0x80000000 / 0xFFFFFFFF -> q_out=0x80000000, r_out=0.
REQ-038 WIDTH=32, either mode, 0x1234 / 0 -> q_out=0xFFFFFFFF, r_out=0x1234, div_zero=1, busy exactly 2 cycles.
REQ-039 WIDTH=8, unsigned, 255 / 16 -> q_out=15, r_out=15, busy 10 cycles; start pulsed mid-LOOP is ignored.
REQ-040 Assert rstLow=0 during LOOP -> busy, q_out, r_out drop to 0 immediately without waiting for a clock edge; no done pulse; next start completes normally.
